// File: rtl/wire_out_arbiter_pkg.sv
// Shared definitions for the Wire Out arbiter: tag layout, sequence rules and
// the two-state hold/acknowledge FSM encoding.
package wire_out_arbiter_pkg;

    localparam int TAG_SEQ_MSB   = 15;
    localparam int TAG_SEQ_LSB   = 8;
    localparam int TAG_SRC_MSB   = 6;
    localparam int TAG_SRC_LSB   = 4;
    localparam int TAG_VALID_BIT = 0;

    localparam logic [7:0] SEQ_RESET = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Zero is reserved so the host's power-up Wire In value never matches.
    function automatic logic [7:0] seq_next(input logic [7:0] s);
        return (s == 8'hFF) ? 8'h01 : s + 8'h01;
    endfunction

endpackage

// File: rtl/wire_out_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// searching upward modulo N.
module rr_arbiter
    import wire_out_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/wire_out_arbiter.sv
// Multiplexes N requesters onto one data/tag Wire Out pair; each word is held
// until the host echoes its sequence number back on ack_wire[7:0].
module wire_out_arbiter
    import wire_out_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            ti_clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [16*N-1:0] req_data,
    output logic [N-1:0]    req_ready,
    input  logic [15:0]     ack_wire,
    output logic [15:0]     out_data,
    output logic [15:0]     out_tag,
    output state_e          state_dbg
);

    localparam int IW = idx_width(N);

    state_e          state_q, state_d;
    logic [7:0]      seq_q, seq_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   src_q, src_d;
    logic [15:0]     out_data_q, out_data_d;

    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic            xfer;
    logic            ack_hit;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Handshake: req_ready is a one-hot grant raised only in IDLE; a word moves
    // on the edge where req_valid[i] & req_ready[i], with no back-pressure beyond that.
    assign xfer    = (state_q == IDLE) && grant_any;
    assign ack_hit = (state_q == HOLD) && (ack_wire[7:0] == seq_q);

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            seq_q      <= SEQ_RESET;
            rr_ptr_q   <= '0;
            src_q      <= '0;
            out_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            rr_ptr_q   <= rr_ptr_d;
            src_q      <= src_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = HOLD;
            HOLD:    if (ack_hit)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seq_d      = seq_q;
        rr_ptr_d   = rr_ptr_q;
        src_d      = src_q;
        out_data_d = out_data_q;
        if (xfer) begin
            out_data_d = req_data[16*int'(grant_idx) +: 16];
            src_d      = grant_idx;
        end
        if (ack_hit) begin
            seq_d    = seq_next(seq_q);
            rr_ptr_d = IW'((int'(src_q) + 1) % N);
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? grant : '0;
        out_tag   = '0;
        out_tag[TAG_SEQ_MSB:TAG_SEQ_LSB] = seq_q;
        out_tag[TAG_SRC_MSB:TAG_SRC_LSB] = 3'(src_q);
        out_tag[TAG_VALID_BIT]           = (state_q == HOLD);
    end

    assign out_data  = out_data_q;
    assign state_dbg = state_q;

endmodule
